// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, stage state encoding and the S-box tables.
// Table entry n occupies bits [8n:8n+7], so byte 0x00 sits at the MSB end of each table.
package aes_pkg;

  localparam int BLOCK_BITS = 128;
  localparam int BYTE_BITS  = 8;
  localparam int NUM_BYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [0:2047] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX_BITS = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX_BITS[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox_lookup(input logic [7:0] b);
    return INV_SBOX_BITS[{b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box: purely combinational lookup into the shared table.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_BITS-1:0] byte_i,
  output logic [BYTE_BITS-1:0] byte_o
);

  assign byte_o = inv_sbox_lookup(byte_i);

endmodule

// File: rtl/inv_sub_bytes_lp.sv
// Area/power-reduced InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes sweep the
// captured block over 16/BYTES_PER_CYCLE cycles, then publish it with a one-cycle pronto.
module inv_sub_bytes_lp
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enableS,
  input  logic [0:BLOCK_BITS-1] blocoIn,
  output logic [0:BLOCK_BITS-1] blocoOut,
  output logic                  pronto,
  output logic                  ocupado
);

  localparam logic [3:0] IDX_STEP = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] IDX_LAST = 4'(NUM_BYTES - BYTES_PER_CYCLE);

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [0:BLOCK_BITS-1]   trab_q, trab_d;
  logic [0:BLOCK_BITS-1]   out_q, out_d;
  logic [6:0]              bit_base;
  logic [BYTE_BITS-1:0]    sb_in  [BYTES_PER_CYCLE];
  logic [BYTE_BITS-1:0]    sb_out [BYTES_PER_CYCLE];

  // Bit offset of the first byte in the current group.
  assign bit_base = {idx_q, 3'b000};

  generate
    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
      assign sb_in[gi] = trab_q[bit_base + 7'(gi * BYTE_BITS) +: BYTE_BITS];
      inv_sbox u_inv_sbox (
        .byte_i(sb_in[gi]),
        .byte_o(sb_out[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    trab_d  = trab_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (enableS) begin
          trab_d  = blocoIn;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
          trab_d[bit_base + 7'(g * BYTE_BITS) +: BYTE_BITS] = sb_out[g];
        end
        idx_d = idx_q + IDX_STEP;
        // Last group: publish the fully substituted block in the same edge.
        if (idx_q == IDX_LAST) begin
          out_d   = trab_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      trab_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      trab_q  <= trab_d;
      out_q   <= out_d;
    end
  end

  assign blocoOut = out_q;
  assign pronto   = (state_q == ST_DONE);
  assign ocupado  = (state_q == ST_RUN);

endmodule

// File: tb/tb_inv_sub_bytes_lp.sv
// Bench for inv_sub_bytes_lp: three widths (1, 4, 16 bytes/cycle) share the stimulus;
// the 1-byte instance is tracked through a result scoreboard.
module tb_inv_sub_bytes_lp;
  import aes_pkg::*;

  localparam int NI = 3;

  typedef struct {
    logic [0:127] blk;
    logic [0:127] exp;
  } vec_t;

  logic         clock;
  logic         reset;
  logic         enableS;
  logic [0:127] blocoIn;
  logic [0:127] out_w [NI];
  logic         pr_w  [NI];
  logic         oc_w  [NI];

  int           checks   = 0;
  int           failures = 0;
  int           lat_exp  [NI];
  logic [0:127] sb_q [$];
  vec_t         vt [13];

  inv_sub_bytes_lp #(.BYTES_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .enableS(enableS), .blocoIn(blocoIn),
    .blocoOut(out_w[0]), .pronto(pr_w[0]), .ocupado(oc_w[0]));
  inv_sub_bytes_lp #(.BYTES_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .enableS(enableS), .blocoIn(blocoIn),
    .blocoOut(out_w[1]), .pronto(pr_w[1]), .ocupado(oc_w[1]));
  inv_sub_bytes_lp #(.BYTES_PER_CYCLE(16)) dut16 (
    .clock(clock), .reset(reset), .enableS(enableS), .blocoIn(blocoIn),
    .blocoOut(out_w[2]), .pronto(pr_w[2]), .ocupado(oc_w[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [0:127] fwd_block(input logic [0:127] b);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_lookup(b[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [0:127] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pop_chk(input string name);
    logic [0:127] e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got unexpected pronto expected none", name);
    end else begin
      e = sb_q.pop_front();
      checks--;
      chk(name, out_w[0], e);
    end
  endtask

  // One operation started by a single-edge pulse; all three widths checked.
  task automatic run_op(input string name, input logic [0:127] blk, input logic [0:127] exp);
    logic [0:127] prev [NI];
    int           lat  [NI];
    int           busy0;
    bit           held;
    for (int i = 0; i < NI; i++) begin
      prev[i] = out_w[i];
      lat[i]  = 0;
    end
    busy0 = 0;
    held  = 1'b1;
    sb_q.push_back(exp);
    blocoIn = blk;
    enableS = 1'b1;
    tick();
    enableS = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      if (oc_w[0]) busy0++;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] == 0 && pr_w[i]) begin
          lat[i] = c;
          if (i == 0) pop_chk({name, "_out_i0"});
          else chk($sformatf("%s_out_i%0d", name, i), out_w[i], exp);
        end else if (lat[i] == 0 && out_w[i] !== prev[i]) begin
          held = 1'b0;
        end
      end
    end
    for (int i = 0; i < NI; i++)
      chk_int($sformatf("%s_latency_i%0d", name, i), lat[i], lat_exp[i]);
    chk_int({name, "_ocupado_cycles"}, busy0, 16);
    chk_int({name, "_out_held_before_pronto"}, int'(held), 1);
    $display("op %s: in=%h out=%h", name, blk, out_w[0]);
  endtask

  initial begin
    int np;
    int last;
    lat_exp[0] = 16;
    lat_exp[1] = 4;
    lat_exp[2] = 1;

    vt[0] = '{128'hd4e0b81e27bfb44111985d52aef1e530, 128'h19a09ae93df4c6f8e3e28d48be2b2a08};
    vt[1] = '{{16{8'h63}}, {16{8'h00}}};
    vt[2] = '{{16{8'h00}}, {16{8'h52}}};
    vt[3] = '{{16{8'h7c}}, {16{8'h01}}};
    vt[4] = '{128'h49457f77dedb3902d296875389f11a3b, 128'ha4686b029c9f5b6a7f35ea50f22b4349};
    for (int k = 5; k < 13; k++) begin
      vt[k].exp = rand_block();
      vt[k].blk = fwd_block(vt[k].exp);
    end

    reset   = 1'b0;
    enableS = 1'b0;
    blocoIn = '0;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_out_i%0d", i), out_w[i], '0);
      chk_int($sformatf("reset_pronto_i%0d", i), int'(pr_w[i]), 0);
      chk_int($sformatf("reset_ocupado_i%0d", i), int'(oc_w[i]), 0);
    end
    reset = 1'b1;
    tick();

    for (int k = 0; k < 13; k++) run_op($sformatf("vec%0d", k), vt[k].blk, vt[k].exp);

    // Re-pulse and change the input while busy: exactly one result, from the E0 capture.
    np = 0;
    sb_q.push_back(vt[0].exp);
    blocoIn = vt[0].blk;
    enableS = 1'b1;
    tick();
    enableS = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) tick();
      if (c == 3) blocoIn = rand_block();
      if (c == 5) enableS = 1'b1;
      if (c == 6) enableS = 1'b0;
      if (pr_w[0]) begin
        np++;
        if (np == 1) begin
          pop_chk("ignored_en_out");
          chk_int("ignored_en_latency", c, 16);
        end
      end
    end
    chk_int("ignored_en_pronto_count", np, 1);
    $display("op ignored_en: out=%h prontos=%0d", out_w[0], np);

    // Async reset at cycle 8 of RUN, checked between clock edges.
    blocoIn = vt[1].blk;
    enableS = 1'b1;
    tick();
    enableS = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk_int("pre_reset_ocupado", int'(oc_w[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset_out", out_w[0], '0);
    chk_int("midrun_reset_pronto", int'(pr_w[0]), 0);
    chk_int("midrun_reset_ocupado", int'(oc_w[0]), 0);
    $display("op midrun_reset: out=%h ocupado=%0d", out_w[0], oc_w[0]);
    tick();
    tick();
    reset = 1'b1;
    run_op("after_reset", vt[1].blk, vt[1].exp);

    // Held enable: a new operation every N+2 cycles.
    np   = 0;
    last = 0;
    for (int k = 0; k < 3; k++) sb_q.push_back(vt[4].exp);
    blocoIn = vt[4].blk;
    enableS = 1'b1;
    tick();
    for (int c = 0; c <= 70 && np < 3; c++) begin
      if (c > 0) tick();
      if (pr_w[0]) begin
        np++;
        pop_chk($sformatf("held_en_out%0d", np));
        chk_int($sformatf("held_en_interval%0d", np), c - last, (np == 1) ? 16 : 18);
        $display("op held_en%0d: cycle=%0d out=%h", np, c, out_w[0]);
        last = c;
        if (np == 3) enableS = 1'b0;
      end
    end
    enableS = 1'b0;
    chk_int("held_en_pronto_count", np, 3);
    sb_q.delete();
    for (int c = 0; c < 24; c++) tick();
    chk_int("final_idle_ocupado", int'(oc_w[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
